// File: rtl/encrypt_pkg.sv
// rtl/encrypt_pkg.sv - shared types, sizing helpers and default-build constants for the LWE encrypt stream
package encrypt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Counter width that never collapses to zero bits, even for a range of one.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int row_width(input int dimension);
        return clog2_min1(dimension + 1);
    endfunction

    function automatic int beats_per_row(input int big_n, input int lanes);
        return (big_n + lanes - 1) / lanes;
    endfunction

    // Values for the default build (BIG_N=30, LANES=1, CW=10, PW=6, DIMENSION=1).
    localparam int BEATS       = beats_per_row(30, 1);
    localparam int SCALE_SHIFT = 10 - 6;
    localparam int ROW_W       = row_width(1);

endpackage

// File: rtl/encrypt_lane_sum.sv
// rtl/encrypt_lane_sum.sv - masked sum of one public-key beat, reduced mod 2^CW
//
// Ports:
//   lane_data  : LANES entries, lane j at [j*CW +: CW]
//   lane_mask  : per-lane subset-select bit from the noise mask
//   lane_valid : per-lane flag, low for padding lanes past the end of a row
//   sum        : sum of selected, valid lanes modulo 2^CW
module encrypt_lane_sum #(
    parameter int LANES = 1,
    parameter int CW    = 10
) (
    input  logic [LANES*CW-1:0] lane_data,
    input  logic [LANES-1:0]    lane_mask,
    input  logic [LANES-1:0]    lane_valid,
    output logic [CW-1:0]       sum
);

    // Wide enough that the full adder chain never overflows before reduction.
    localparam int SUM_W = CW + $clog2(LANES + 1);

    logic [SUM_W-1:0] total;

    always_comb begin
        total = '0;
        for (int j = 0; j < LANES; j++) begin
            if (lane_mask[j] && lane_valid[j]) begin
                total = total + SUM_W'(lane_data[j*CW +: CW]);
            end
        end
    end

    assign sum = CW'(total % SUM_W'(2 ** CW));

endmodule

// File: rtl/encrypt_stream.sv
// rtl/encrypt_stream.sv - streaming LWE encrypt: one request, DIMENSION+1 ciphertext rows
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake (ready while idle)
//   req_plaintext, req_noise_select : message and per-entry subset mask
//   pk_valid/pk_ready/pk_data       : public-key beats, LANES entries each, row-major
//   ct_valid/ct_ready               : ciphertext element handshake
//   ct_data, ct_row, ct_last        : element value, its row, high on the final row
//   busy                            : request accepted and not yet fully emitted
module encrypt_stream
    import encrypt_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 1,
    parameter int BIG_N              = 30,
    parameter int LANES              = 1,
    parameter int ENCODE             = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [PLAINTEXT_WIDTH-1:0]            req_plaintext,
    input  logic [BIG_N-1:0]                      req_noise_select,
    input  logic                                  pk_valid,
    output logic                                  pk_ready,
    input  logic [LANES*CIPHERTEXT_WIDTH-1:0]     pk_data,
    output logic                                  ct_valid,
    input  logic                                  ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0]           ct_data,
    output logic [row_width(DIMENSION)-1:0]       ct_row,
    output logic                                  ct_last,
    output logic                                  busy
);

    localparam int CW        = CIPHERTEXT_WIDTH;
    localparam int NUM_BEATS = beats_per_row(BIG_N, LANES);
    localparam int SHIFT     = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
    localparam int RW        = row_width(DIMENSION);
    localparam int BEAT_W    = clog2_min1(NUM_BEATS);

    state_t state, state_next;

    logic [PLAINTEXT_WIDTH-1:0] pt_q;
    logic [BIG_N-1:0]           mask_q;
    logic [CW-1:0]              acc;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [RW-1:0]              row;

    logic [LANES-1:0] lane_mask;
    logic [LANES-1:0] lane_valid;
    logic [CW-1:0]    beat_sum;
    logic [CW-1:0]    msg_term;
    logic             last_beat;
    logic             last_row;

    assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));
    assign last_row  = (row == RW'(DIMENSION));

    // The message is folded into row 0 only; ENCODE scales it to the top of the q range.
    assign msg_term = (ENCODE != 0) ? (CW'(pt_q) << SHIFT) : CW'(pt_q);

    // Mask bits for the current beat; lanes beyond BIG_N on the final beat are padding.
    always_comb begin
        lane_mask = LANES'(mask_q >> (int'(beat_cnt) * LANES));
        for (int j = 0; j < LANES; j++) begin
            lane_valid[j] = ((int'(beat_cnt) * LANES + j) < BIG_N);
        end
    end

    encrypt_lane_sum #(
        .LANES (LANES),
        .CW    (CW)
    ) u_lane_sum (
        .lane_data  (pk_data),
        .lane_mask  (lane_mask),
        .lane_valid (lane_valid),
        .sum        (beat_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACCUM;
            ACCUM:   if (pk_valid && last_beat) state_next = EMIT;
            EMIT:    if (ct_ready) state_next = last_row ? IDLE : ACCUM;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        pk_ready  = (state == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_q     <= '0;
            mask_q   <= '0;
            acc      <= '0;
            beat_cnt <= '0;
            row      <= '0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
            ct_row   <= '0;
            ct_last  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pt_q     <= req_plaintext;
                        mask_q   <= req_noise_select;
                        acc      <= '0;
                        beat_cnt <= '0;
                        row      <= '0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (pk_valid) begin
                        if (last_beat) begin
                            ct_data  <= acc + beat_sum + ((row == '0) ? msg_term : '0);
                            ct_valid <= 1'b1;
                            ct_row   <= row;
                            ct_last  <= last_row;
                        end else begin
                            acc      <= acc + beat_sum;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (ct_ready) begin
                        ct_valid <= 1'b0;
                        acc      <= '0;
                        beat_cnt <= '0;
                        if (last_row) begin
                            busy <= 1'b0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_stream.sv
// tb/tb_encrypt_stream.sv - self-checking bench for encrypt_stream (1-lane legacy and 4-lane scaled builds)
module tb_encrypt_stream;

    localparam int CW = 10;
    localparam int PW = 6;
    localparam int NN = 30;
    localparam logic [NN-1:0] M1 = 30'h2A3B39B9;

    localparam int S1_R0 [NN] = '{320, 909, 721, 278, 946, 806, 193, 593, 121, 418,
                                  739, 642, 648, 873, 279, 1023, 643, 129, 666, 962,
                                  869, 165, 698, 821, 744, 837, 466, 394, 192, 588};
    localparam int S1_R1 [NN] = '{576, 847, 763, 626, 294, 34, 651, 187, 819, 246,
                                  321, 854, 24, 67, 701, 117, 865, 331, 350, 150,
                                  407, 407, 318, 135, 760, 567, 70, 430, 320, 388};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst_n, req_valid, req_ready, pk_valid, pk_ready;
    logic [1:0]         ct_valid, ct_ready, ct_last, busy, ct_row;
    logic [1:0][PW-1:0] req_pt;
    logic [1:0][NN-1:0] req_mask;
    logic [1:0][CW-1:0] ct_data;
    logic [CW-1:0]      pk_data_a;
    logic [4*CW-1:0]    pk_data_b;

    encrypt_stream #(.LANES(1), .ENCODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_plaintext(req_pt[0]), .req_noise_select(req_mask[0]),
        .pk_valid(pk_valid[0]), .pk_ready(pk_ready[0]), .pk_data(pk_data_a),
        .ct_valid(ct_valid[0]), .ct_ready(ct_ready[0]), .ct_data(ct_data[0]),
        .ct_row(ct_row[0]), .ct_last(ct_last[0]), .busy(busy[0])
    );

    encrypt_stream #(.LANES(4), .ENCODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_plaintext(req_pt[1]), .req_noise_select(req_mask[1]),
        .pk_valid(pk_valid[1]), .pk_ready(pk_ready[1]), .pk_data(pk_data_b),
        .ct_valid(ct_valid[1]), .ct_ready(ct_ready[1]), .ct_data(ct_data[1]),
        .ct_row(ct_row[1]), .ct_last(ct_last[1]), .busy(busy[1])
    );

    int errors = 0;
    int checks = 0;
    int ent [2][NN];

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Ciphertext element r = (selected entries of row r, plus the message on row 0) mod q.
    function automatic int model_row(input int d, input int r, input int pt, input logic [NN-1:0] mask);
        int s = 0;
        for (int i = 0; i < NN; i++) if (mask[i]) s += ent[r][i];
        if (r == 0) s += (d == 1) ? pt * (1 << (CW - PW)) : pt;
        return s % (1 << CW);
    endfunction

    task automatic load_s1();
        for (int i = 0; i < NN; i++) begin
            ent[0][i] = S1_R0[i];
            ent[1][i] = S1_R1[i];
        end
    endtask

    task automatic load_const(input int v);
        for (int i = 0; i < NN; i++) begin
            ent[0][i] = v;
            ent[1][i] = v;
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < NN; i++) begin
            ent[0][i] = $urandom_range(0, (1 << CW) - 1);
            ent[1][i] = $urandom_range(0, (1 << CW) - 1);
        end
    endtask

    // Lanes past the end of the row carry all-ones junk that must not be summed.
    task automatic drive_beat(input int d, input int r, input int k);
        int lanes = (d == 0) ? 1 : 4;
        int idx;
        logic [CW-1:0] v;
        for (int j = 0; j < lanes; j++) begin
            idx = k * lanes + j;
            v = (idx < NN) ? CW'(ent[r][idx]) : '1;
            if (d == 0) pk_data_a = v;
            else pk_data_b[j*CW +: CW] = v;
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_req_ready", req_ready[d], 1);
        check("rst_pk_ready", pk_ready[d], 0);
        check("rst_ct_valid", ct_valid[d], 0);
        check("rst_ct_data", ct_data[d], 0);
        check("rst_ct_row", ct_row[d], 0);
        check("rst_ct_last", ct_last[d], 0);
        check("rst_busy", busy[d], 0);
    endtask

    // One full request; stall < 0 picks a random ct_ready delay per row.
    task automatic run_txn(input int d, input int pt, input logic [NN-1:0] mask,
                           input int stall, input bit pulse_req);
        int lanes = (d == 0) ? 1 : 4;
        int beats = (NN + lanes - 1) / lanes;
        int guard;
        int k;
        int n_stall;
        int exp_v;
        bit rdy;
        guard = 0;
        @(negedge clk);
        while (!req_ready[d] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", req_ready[d], 1);
        req_valid[d] = 1'b1;
        req_pt[d]    = PW'(pt);
        req_mask[d]  = mask;
        @(negedge clk);
        req_valid[d] = pulse_req;
        req_pt[d]    = PW'(pt) ^ 6'h15;
        req_mask[d]  = ~mask;
        check("busy_set", busy[d], 1);
        check("req_ready_busy", req_ready[d], 0);
        for (int r = 0; r < 2; r++) begin
            k = 0;
            guard = 0;
            while (k < beats && guard < 500) begin
                if ($urandom_range(0, 3) == 0) begin
                    pk_valid[d] = 1'b0;
                end else begin
                    pk_valid[d] = 1'b1;
                    drive_beat(d, r, k);
                end
                rdy = pk_ready[d];
                @(posedge clk);
                if (rdy && pk_valid[d]) k++;
                @(negedge clk);
                guard++;
            end
            if (k < beats) check("beat_timeout", k, beats);
            req_valid[d] = 1'b0;
            pk_valid[d] = (stall > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pk_data_a = CW'($urandom);
            pk_data_b = {8'($urandom), $urandom};
            exp_v = model_row(d, r, pt, mask);
            check("ct_valid", ct_valid[d], 1);
            check("ct_data", ct_data[d], exp_v);
            check("ct_row", ct_row[d], r);
            check("ct_last", ct_last[d], (r == 1) ? 1 : 0);
            check("pk_ready_emit", pk_ready[d], 0);
            n_stall = (stall < 0) ? $urandom_range(0, 3) : stall;
            for (int s = 0; s < n_stall; s++) begin
                @(negedge clk);
                check("ct_hold_data", ct_data[d], exp_v);
                check("ct_hold_valid", ct_valid[d], 1);
                check("pk_ready_stall", pk_ready[d], 0);
            end
            ct_ready[d] = 1'b1;
            @(negedge clk);
            ct_ready[d] = 1'b0;
            pk_valid[d] = 1'b0;
            check("ct_valid_clr", ct_valid[d], 0);
            if (r == 1) begin
                check("busy_clr", busy[d], 0);
                check("req_ready_back", req_ready[d], 1);
            end else begin
                check("pk_ready_next", pk_ready[d], 1);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = '0; req_valid = '0; pk_valid = '0; ct_ready = '0;
        req_pt = '0; req_mask = '0; pk_data_a = '0; pk_data_b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n = 2'b11;

        // 1-lane legacy build: directed scenario, backpressure, boundaries.
        load_s1();
        check("s1_model_row0", model_row(0, 0, 2, M1), 600);
        run_txn(0, 2, M1, 0, 1'b0);
        run_txn(0, 2, M1, 5, 1'b0);
        load_s1();
        run_txn(0, 5, '0, -1, 1'b0);
        load_const(1023);
        run_txn(0, 0, '1, -1, 1'b0);

        // Reset after three beats of row 0.
        load_s1();
        @(negedge clk);
        req_valid[0] = 1'b1; req_pt[0] = 6'd2; req_mask[0] = M1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            pk_valid[0] = 1'b1;
            drive_beat(0, 0, b);
            @(negedge clk);
        end
        pk_valid[0] = 1'b0;
        rst_n[0] = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", req_ready[0], 1);
        run_txn(0, 2, M1, -1, 1'b1);

        for (int n = 0; n < 8; n++) begin
            load_random();
            run_txn(0, $urandom_range(0, 63), NN'($urandom), -1, 1'(n % 2));
        end

        // 4-lane scaled build: directed, boundaries, random.
        load_s1();
        check("s2_model_row0", model_row(1, 0, 2, M1), 630);
        run_txn(1, 2, M1, -1, 1'b0);
        run_txn(1, 5, '0, -1, 1'b1);
        load_const(1023);
        run_txn(1, 0, '1, 2, 1'b0);
        for (int n = 0; n < 8; n++) begin
            load_random();
            run_txn(1, $urandom_range(0, 63), NN'($urandom), -1, 1'(n % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
